// File: rtl/behavior_arbiter.sv
// Robot behaviour arbiter: STOP / GOTOGOAL / AVOID / GOAL with timed obstacle-avoidance dwell.
// Latency: distances captured at edge n, state and outputs at edge n+1; no backpressure.
module behavior_arbiter #(
    parameter int                 N_WIDTH     = 17,
    parameter int                 B_WIDTH     = 8,
    parameter logic [N_WIDTH-1:0] THRESH      = 17'd300,
    parameter logic [N_WIDTH-1:0] V_AVOID     = 17'd200,
    parameter int                 HOLD_CYCLES = 25000000
) (
    input  logic               BEHAVIOR_ARBITER_CLOCK_50,
    input  logic               BEHAVIOR_ARBITER_RESET_InLow,
    input  logic [N_WIDTH-1:0] BEHAVIOR_ARBITER_DIST1_InBus,
    input  logic [N_WIDTH-1:0] BEHAVIOR_ARBITER_DIST2_InBus,
    input  logic [N_WIDTH-1:0] BEHAVIOR_ARBITER_DIST3_InBus,
    input  logic [N_WIDTH-1:0] BEHAVIOR_ARBITER_DIST4_InBus,
    input  logic               BEHAVIOR_ARBITER_NEWSIGNAL_InLow,
    input  logic               BEHAVIOR_ARBITER_STOP_InLow,
    input  logic               BEHAVIOR_ARBITER_FLAGGOAL_InLow,
    input  logic [N_WIDTH-1:0] BEHAVIOR_ARBITER_ERRORX_InBus,
    input  logic [N_WIDTH-1:0] BEHAVIOR_ARBITER_ERRORY_InBus,
    output logic [B_WIDTH-1:0] BEHAVIOR_ARBITER_CURRENTBEH_OutBus,
    output logic [1:0]         BEHAVIOR_ARBITER_MUXSELECT_OutBus,
    output logic [N_WIDTH-1:0] BEHAVIOR_ARBITER_VELX_OutBus,
    output logic [N_WIDTH-1:0] BEHAVIOR_ARBITER_VELY_OutBus
);

    localparam logic [24:0]        HOLD_LOAD = 25'(HOLD_CYCLES - 1);
    localparam logic [N_WIDTH-1:0] V_NEG     = {N_WIDTH{1'b0}} - V_AVOID;

    localparam logic [B_WIDTH-1:0] BEH_STOP  = B_WIDTH'(83);
    localparam logic [B_WIDTH-1:0] BEH_GOTO  = B_WIDTH'(80);
    localparam logic [B_WIDTH-1:0] BEH_AVOID = B_WIDTH'(65);
    localparam logic [B_WIDTH-1:0] BEH_GOAL  = B_WIDTH'(71);

    localparam logic [1:0] MUX_STOP  = 2'b00;
    localparam logic [1:0] MUX_GOTO  = 2'b01;
    localparam logic [1:0] MUX_AVOID = 2'b10;

    typedef enum logic [1:0] {
        ST_STOP,
        ST_GOTOGOAL,
        ST_AVOID,
        ST_GOAL
    } state_t;

    state_t             state;
    logic [24:0]        holdCnt;
    logic [N_WIDTH-1:0] distQ [4];
    logic [N_WIDTH-1:0] distIn [4];

    logic               obstacle;
    logic [1:0]         nearest;
    logic [N_WIDTH-1:0] nearestDist;
    logic [N_WIDTH-1:0] avoidVelX;
    logic [N_WIDTH-1:0] avoidVelY;

    assign distIn[0] = BEHAVIOR_ARBITER_DIST1_InBus;
    assign distIn[1] = BEHAVIOR_ARBITER_DIST2_InBus;
    assign distIn[2] = BEHAVIOR_ARBITER_DIST3_InBus;
    assign distIn[3] = BEHAVIOR_ARBITER_DIST4_InBus;

    // Zero means no echo; strict '<' on the running minimum keeps the lowest index on ties.
    always_comb begin
        obstacle    = 1'b0;
        nearest     = 2'd0;
        nearestDist = '1;
        for (int k = 0; k < 4; k++) begin
            if (distQ[k] != '0 && distQ[k] < THRESH) begin
                if (!obstacle || distQ[k] < nearestDist) begin
                    nearest     = 2'(k);
                    nearestDist = distQ[k];
                end
                obstacle = 1'b1;
            end
        end
    end

    // Front/back sensors (index 0/2) steer along X, side sensors along Y.
    always_comb begin
        avoidVelX = '0;
        avoidVelY = '0;
        if (!nearest[0]) begin
            avoidVelX = BEHAVIOR_ARBITER_ERRORX_InBus[N_WIDTH-1] ? V_NEG : V_AVOID;
        end else begin
            avoidVelY = BEHAVIOR_ARBITER_ERRORY_InBus[N_WIDTH-1] ? V_NEG : V_AVOID;
        end
    end

    always_ff @(posedge BEHAVIOR_ARBITER_CLOCK_50 or negedge BEHAVIOR_ARBITER_RESET_InLow) begin
        if (!BEHAVIOR_ARBITER_RESET_InLow) begin
            state                              <= ST_STOP;
            holdCnt                            <= '0;
            BEHAVIOR_ARBITER_CURRENTBEH_OutBus <= BEH_STOP;
            BEHAVIOR_ARBITER_MUXSELECT_OutBus  <= MUX_STOP;
            BEHAVIOR_ARBITER_VELX_OutBus       <= '0;
            BEHAVIOR_ARBITER_VELY_OutBus       <= '0;
            for (int k = 0; k < 4; k++) begin
                distQ[k] <= '0;
            end
        end else begin
            if (!BEHAVIOR_ARBITER_NEWSIGNAL_InLow) begin
                for (int k = 0; k < 4; k++) begin
                    distQ[k] <= distIn[k];
                end
            end

            if (!BEHAVIOR_ARBITER_STOP_InLow) begin
                state                              <= ST_STOP;
                holdCnt                            <= '0;
                BEHAVIOR_ARBITER_CURRENTBEH_OutBus <= BEH_STOP;
                BEHAVIOR_ARBITER_MUXSELECT_OutBus  <= MUX_STOP;
                BEHAVIOR_ARBITER_VELX_OutBus       <= '0;
                BEHAVIOR_ARBITER_VELY_OutBus       <= '0;
            end else begin
                case (state)
                    ST_STOP: begin
                        state                              <= ST_GOTOGOAL;
                        BEHAVIOR_ARBITER_CURRENTBEH_OutBus <= BEH_GOTO;
                        BEHAVIOR_ARBITER_MUXSELECT_OutBus  <= MUX_GOTO;
                    end
                    ST_GOTOGOAL: begin
                        if (!BEHAVIOR_ARBITER_FLAGGOAL_InLow) begin
                            state                              <= ST_GOAL;
                            BEHAVIOR_ARBITER_CURRENTBEH_OutBus <= BEH_GOAL;
                            BEHAVIOR_ARBITER_MUXSELECT_OutBus  <= MUX_STOP;
                        end else if (obstacle) begin
                            state                              <= ST_AVOID;
                            holdCnt                            <= HOLD_LOAD;
                            BEHAVIOR_ARBITER_CURRENTBEH_OutBus <= BEH_AVOID;
                            BEHAVIOR_ARBITER_MUXSELECT_OutBus  <= MUX_AVOID;
                            BEHAVIOR_ARBITER_VELX_OutBus       <= avoidVelX;
                            BEHAVIOR_ARBITER_VELY_OutBus       <= avoidVelY;
                        end
                    end
                    ST_AVOID: begin
                        if (holdCnt != '0) begin
                            holdCnt <= holdCnt - 25'd1;
                        end else if (!obstacle) begin
                            state                              <= ST_GOTOGOAL;
                            BEHAVIOR_ARBITER_CURRENTBEH_OutBus <= BEH_GOTO;
                            BEHAVIOR_ARBITER_MUXSELECT_OutBus  <= MUX_GOTO;
                            BEHAVIOR_ARBITER_VELX_OutBus       <= '0;
                            BEHAVIOR_ARBITER_VELY_OutBus       <= '0;
                        end else begin
                            // Obstacle still present: restart the dwell with a fresh heading.
                            holdCnt                      <= HOLD_LOAD;
                            BEHAVIOR_ARBITER_VELX_OutBus <= avoidVelX;
                            BEHAVIOR_ARBITER_VELY_OutBus <= avoidVelY;
                        end
                    end
                    ST_GOAL: begin
                        if (BEHAVIOR_ARBITER_FLAGGOAL_InLow) begin
                            state                              <= ST_GOTOGOAL;
                            BEHAVIOR_ARBITER_CURRENTBEH_OutBus <= BEH_GOTO;
                            BEHAVIOR_ARBITER_MUXSELECT_OutBus  <= MUX_GOTO;
                        end
                    end
                    default: begin
                        state                              <= ST_STOP;
                        BEHAVIOR_ARBITER_CURRENTBEH_OutBus <= BEH_STOP;
                        BEHAVIOR_ARBITER_MUXSELECT_OutBus  <= MUX_STOP;
                        BEHAVIOR_ARBITER_VELX_OutBus       <= '0;
                        BEHAVIOR_ARBITER_VELY_OutBus       <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_behavior_arbiter.sv
// Bench for behavior_arbiter: directed scenarios, behavioural model compared every cycle.
// HOLD_CYCLES shortened to 8 so dwell and reload are observable.
module tb_behavior_arbiter;

    localparam int HOLD = 8;

    localparam int M_STOP  = 0;
    localparam int M_GOTO  = 1;
    localparam int M_AVOID = 2;
    localparam int M_GOAL  = 3;

    logic        clk = 1'b0;
    logic        rstN;
    logic [16:0] dist1, dist2, dist3, dist4;
    logic        newSigN, stopN, flagGoalN;
    logic [16:0] errX, errY;
    logic [7:0]  beh;
    logic [1:0]  mux;
    logic [16:0] velX, velY;

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    behavior_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .BEHAVIOR_ARBITER_CLOCK_50         (clk),
        .BEHAVIOR_ARBITER_RESET_InLow      (rstN),
        .BEHAVIOR_ARBITER_DIST1_InBus      (dist1),
        .BEHAVIOR_ARBITER_DIST2_InBus      (dist2),
        .BEHAVIOR_ARBITER_DIST3_InBus      (dist3),
        .BEHAVIOR_ARBITER_DIST4_InBus      (dist4),
        .BEHAVIOR_ARBITER_NEWSIGNAL_InLow  (newSigN),
        .BEHAVIOR_ARBITER_STOP_InLow       (stopN),
        .BEHAVIOR_ARBITER_FLAGGOAL_InLow   (flagGoalN),
        .BEHAVIOR_ARBITER_ERRORX_InBus     (errX),
        .BEHAVIOR_ARBITER_ERRORY_InBus     (errY),
        .BEHAVIOR_ARBITER_CURRENTBEH_OutBus(beh),
        .BEHAVIOR_ARBITER_MUXSELECT_OutBus (mux),
        .BEHAVIOR_ARBITER_VELX_OutBus      (velX),
        .BEHAVIOR_ARBITER_VELY_OutBus      (velY)
    );

    // ---------------- behavioural model ----------------
    int mCap [4];
    int mMode = M_STOP;
    int mAge  = 0;   // edges since the avoidance heading was last chosen
    int mVx   = 0;
    int mVy   = 0;

    // Returns 1..4 for the nearest real obstacle, 0 when none.
    function automatic int nearestSensor();
        int best  = 0;
        int bestD = 0;
        for (int k = 0; k < 4; k++) begin
            if (mCap[k] > 0 && mCap[k] < 300 && (best == 0 || mCap[k] < bestD)) begin
                best  = k + 1;
                bestD = mCap[k];
            end
        end
        return best;
    endfunction

    function automatic int vxFor(input int s);
        if (s == 1 || s == 3) return ($signed(errX) < 0) ? -200 : 200;
        return 0;
    endfunction

    function automatic int vyFor(input int s);
        if (s == 2 || s == 4) return ($signed(errY) < 0) ? -200 : 200;
        return 0;
    endfunction

    function automatic int behOf(input int m);
        case (m)
            M_GOTO:  return 80;
            M_AVOID: return 65;
            M_GOAL:  return 71;
            default: return 83;
        endcase
    endfunction

    function automatic int muxOf(input int m);
        case (m)
            M_GOTO:  return 1;
            M_AVOID: return 2;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int k = 0; k < 4; k++) mCap[k] <= 0;
            mMode <= M_STOP;
            mAge  <= 0;
            mVx   <= 0;
            mVy   <= 0;
        end else begin
            if (!newSigN) begin
                mCap[0] <= int'(dist1);
                mCap[1] <= int'(dist2);
                mCap[2] <= int'(dist3);
                mCap[3] <= int'(dist4);
            end
            if (!stopN) begin
                mMode <= M_STOP;
                mVx   <= 0;
                mVy   <= 0;
            end else if (mMode == M_STOP) begin
                mMode <= M_GOTO;
            end else if (mMode == M_GOTO) begin
                if (!flagGoalN) begin
                    mMode <= M_GOAL;
                end else if (nearestSensor() != 0) begin
                    mMode <= M_AVOID;
                    mAge  <= 0;
                    mVx   <= vxFor(nearestSensor());
                    mVy   <= vyFor(nearestSensor());
                end
            end else if (mMode == M_AVOID) begin
                if (mAge + 1 < HOLD) begin
                    mAge <= mAge + 1;
                end else if (nearestSensor() == 0) begin
                    mMode <= M_GOTO;
                    mVx   <= 0;
                    mVy   <= 0;
                end else begin
                    mAge <= 0;
                    mVx  <= vxFor(nearestSensor());
                    mVy  <= vyFor(nearestSensor());
                end
            end else if (flagGoalN) begin
                mMode <= M_GOTO;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn && rstN) begin
            check("model_beh",  int'(beh), behOf(mMode));
            check("model_mux",  int'(mux), muxOf(mMode));
            check("model_velx", int'($signed(velX)), mVx);
            check("model_vely", int'($signed(velY)), mVy);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic expectOut(input string name, input int b, input int m, input int vx, input int vy);
        check({name, "_beh"},  int'(beh), b);
        check({name, "_mux"},  int'(mux), m);
        check({name, "_velx"}, int'($signed(velX)), vx);
        check({name, "_vely"}, int'($signed(velY)), vy);
    endtask

    // Presents distances with NEWSIGNAL low for exactly one edge.
    task automatic capture(input int d1, input int d2, input int d3, input int d4);
        dist1   = 17'(d1);
        dist2   = 17'(d2);
        dist3   = 17'(d3);
        dist4   = 17'(d4);
        newSigN = 1'b0;
        tick();
        newSigN = 1'b1;
    endtask

    task automatic waitMux(input string name, input int m, input int limit);
        int i = 0;
        while (int'(mux) != m && i < limit) begin
            tick();
            i++;
        end
        check(name, int'(mux), m);
    endtask

    initial begin
        rstN      = 1'b0;
        stopN     = 1'b0;
        newSigN   = 1'b1;
        flagGoalN = 1'b1;
        dist1 = 17'd1000; dist2 = 17'd1000; dist3 = 17'd1000; dist4 = 17'd1000;
        errX  = 17'd0;    errY  = 17'd0;

        tick(2);
        checkEn = 1'b1;
        expectOut("reset", 83, 0, 0, 0);
        rstN = 1'b1;
        tick();
        expectOut("stop_hold", 83, 0, 0, 0);
        stopN = 1'b1;
        tick();
        expectOut("to_goto", 80, 1, 0, 0);

        // Front obstacle, negative X error; dwell of exactly 8 cycles.
        errX = 17'(-5);
        capture(100, 1000, 1000, 1000);
        expectOut("capture_edge", 80, 1, 0, 0);
        tick();
        expectOut("avoid_front", 65, 2, -200, 0);
        capture(1000, 1000, 1000, 1000);
        tick(6);
        expectOut("dwell_7", 65, 2, -200, 0);
        tick();
        expectOut("dwell_exit", 80, 1, 0, 0);

        // Side obstacles tied 2/4; persistent obstacle reloads with a fresh heading.
        errY = 17'd3;
        capture(1000, 150, 1000, 150);
        tick();
        expectOut("avoid_right", 65, 2, 0, 200);
        errY = 17'(-7);
        tick(7);
        expectOut("latched_vel", 65, 2, 0, 200);
        tick();
        expectOut("reload", 65, 2, 0, -200);
        capture(1000, 1000, 1000, 1000);
        waitMux("side_exit", 1, 20);

        // Threshold boundary, zero distance ignored.
        capture(300, 1000, 0, 1000);
        tick(2);
        expectOut("at_thresh", 80, 1, 0, 0);
        capture(299, 1000, 0, 1000);
        tick();
        expectOut("below_thresh", 65, 2, -200, 0);
        capture(1000, 1000, 1000, 1000);
        waitMux("thresh_exit", 1, 20);

        capture(400, 260, 0, 260);
        tick();
        expectOut("zero_ignored", 65, 2, 0, -200);
        capture(1000, 1000, 1000, 1000);
        waitMux("zero_exit", 1, 20);

        errX = 17'd9;
        capture(150, 150, 1000, 1000);
        tick();
        expectOut("tie_low_idx", 65, 2, 200, 0);
        capture(1000, 1000, 1000, 1000);
        waitMux("tie_exit", 1, 20);

        // Goal and obstacle in the same cycle: goal wins.
        capture(100, 1000, 1000, 1000);
        flagGoalN = 1'b0;
        tick();
        expectOut("goal_wins", 71, 0, 0, 0);
        tick();
        expectOut("goal_hold", 71, 0, 0, 0);
        flagGoalN = 1'b1;
        tick();
        expectOut("goal_exit", 80, 1, 0, 0);
        tick();
        expectOut("avoid_again", 65, 2, 200, 0);

        // Stop overrides AVOID.
        stopN = 1'b0;
        tick();
        expectOut("stop_avoid", 83, 0, 0, 0);
        stopN = 1'b1;
        tick();
        expectOut("stop_release", 80, 1, 0, 0);
        tick();
        expectOut("avoid_resume", 65, 2, 200, 0);

        // Asynchronous reset between edges.
        @(posedge clk);
        #2 rstN = 1'b0;
        #1 expectOut("async_reset", 83, 0, 0, 0);
        tick();
        rstN = 1'b1;
        tick();
        expectOut("post_reset", 80, 1, 0, 0);
        tick(3);
        expectOut("cleared_caps", 80, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/behavior_arbiter.md
BEHAVIOR_ARBITER -- requirements
Module: behavior_arbiter

Interface
REQ-001 Parameters SHALL be:
- N_WIDTH, 17, distance/error/velocity width.
- B_WIDTH, 8, behavior code width.
- THRESH, 17'd300, obstacle distance threshold (unsigned).
- V_AVOID, 17'd200, avoidance speed magnitude.
- HOLD_CYCLES, 25000000, minimum AVOID dwell (>=1); counter is 25 bits.
REQ-002 Ports SHALL be:
- BEHAVIOR_ARBITER_CLOCK_50  in  1  system clock, 50 MHz.
- BEHAVIOR_ARBITER_RESET_InLow  in  1  reset.
- BEHAVIOR_ARBITER_DIST1..4_InBus  in  N_WIDTH each  unsigned distances; 1 = front(+Y), 2 = right(+X), 3 = back(-Y), 4 = left(-X).
- BEHAVIOR_ARBITER_NEWSIGNAL_InLow  in  1  distances valid while low.
- BEHAVIOR_ARBITER_STOP_InLow  in  1  stop request, active low.
- BEHAVIOR_ARBITER_FLAGGOAL_InLow  in  1  goal reached, active low.
- BEHAVIOR_ARBITER_ERRORX_InBus / ERRORY_InBus  in  N_WIDTH each  signed position error, two's complement.
- BEHAVIOR_ARBITER_CURRENTBEH_OutBus  out  B_WIDTH  active behavior code.
- BEHAVIOR_ARBITER_MUXSELECT_OutBus  out  2  velocity mux select.
- BEHAVIOR_ARBITER_VELX_OutBus / VELY_OutBus  out  N_WIDTH each  signed avoidance velocity.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 Capture: each rising edge with NEWSIGNAL_InLow=0 SHALL register DIST1..4; otherwise the captured values hold.
REQ-005 Obstacle flag SHALL be set iff any captured distance k satisfies 0 < Dk < THRESH. Dk=0 means no echo and is never an obstacle. Dk=THRESH is not an obstacle.
REQ-006 Nearest sensor SHALL be the obstacle sensor with the minimum captured distance. On ties, the lowest index wins.
REQ-007 States SHALL be STOP, GOTOGOAL, AVOID and GOAL, encoded as follows:
- STOP: MUXSELECT 00, CURRENTBEH 83 ('S').
- GOTOGOAL: MUXSELECT 01, CURRENTBEH 80 ('P').
- AVOID: MUXSELECT 10, CURRENTBEH 65 ('A').
- GOAL: MUXSELECT 00, CURRENTBEH 71 ('G').
- MUXSELECT 11 SHALL never be driven.
REQ-008 STOP_InLow=0 SHALL force STOP at the next edge from any state. This has highest priority over all other events in the same cycle.
REQ-009 STOP SHALL go to GOTOGOAL at the first edge with STOP_InLow=1.
REQ-010 GOTOGOAL SHALL go to GOAL if FLAGGOAL_InLow=0. Otherwise it SHALL go to AVOID if the obstacle flag is set. Goal takes priority over obstacle.
REQ-011 On entry to AVOID, the dwell counter SHALL load HOLD_CYCLES-1 and the avoidance velocity SHALL be latched per REQ-012.
REQ-012 Avoidance velocity SHALL be set by the nearest sensor:
- Sensor 1 or 3: VELX = +V_AVOID if ERRORX >= 0, else -V_AVOID; VELY = 0.
- Sensor 2 or 4: VELY = +V_AVOID if ERRORY >= 0, else -V_AVOID; VELX = 0.
REQ-013 In AVOID the counter SHALL decrement each cycle while nonzero. At counter 0:
- If the obstacle flag is clear, go to GOTOGOAL.
- Otherwise reload HOLD_CYCLES-1 and re-latch velocity per REQ-012.
- FLAGGOAL is ignored in AVOID.
REQ-014 GOAL SHALL go to GOTOGOAL at the first edge with FLAGGOAL_InLow=1.
REQ-015 Output registers SHALL update on the same edge as the state. In every state other than AVOID, VELX and VELY SHALL be 0.
REQ-016 Latency SHALL be: distance presented with NEWSIGNAL low at edge n, captured at edge n, AVOID state and outputs at edge n+1.
REQ-017 Velocity arithmetic SHALL be N_WIDTH two's complement; -V_AVOID is the exact negation, with no saturation needed.

Reset
REQ-018 While RESET_InLow=0, regardless of clock:
- state = STOP, MUXSELECT = 00, CURRENTBEH = 83;
- VELX = VELY = 0, counter = 0;
- captured distances = 0, so no obstacle.
REQ-019 Reset asserted mid-AVOID SHALL abort immediately. After release the block SHALL be in STOP and follow REQ-009.

Verification
REQ-020 The bench SHALL cover these directed scenarios, with HOLD_CYCLES=8 and all distances 1000 unless stated:
- Reset then STOP_InLow=1 -> after 1 edge MUXSELECT=01, CURRENTBEH=80, VEL=0.
- In GOTOGOAL, NEWSIGNAL low 1 cycle with DIST1=100, ERRORX=-5 -> next edge AVOID: MUXSELECT=10, CURRENTBEH=65, VELX=-200, VELY=0. Clear obstacle -> returns to 01 exactly 8 cycles after AVOID entry.
- DIST2=150, DIST4=150, ERRORY=+3 -> sensor 2 selected: VELX=0, VELY=+200. Obstacle kept present -> counter reloads and AVOID persists beyond 8 cycles.
- DIST3=0 and DIST1=300 -> no obstacle, remains GOTOGOAL. DIST1=299 -> AVOID.
- FLAGGOAL_InLow=0 and obstacle in the same cycle from GOTOGOAL -> GOAL (00/71). FLAGGOAL_InLow=1 -> GOTOGOAL.
- STOP_InLow=0 during AVOID -> next edge 00/83, VEL=0. Async reset asserted between edges -> outputs reset without a clock edge.
